// File: rtl/nibble_bus_receiver_pkg.sv
// Shared constants for the nibble bus receiver: data widths, timer width and FSM encodings.
package nibble_bus_receiver_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned TMR_W    = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HALF = 1'b1;

endpackage

// File: rtl/nibble_bus_receiver_byte_fifo.sv
// Byte FIFO with level count; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo
    import nibble_bus_receiver_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        push_data,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              pop_ok_c;
    logic              push_ok_c;

    assign empty     = (count == '0);
    assign full      = (count == LVL_W'(DEPTH));
    assign pop_ok_c  = pop && !empty;
    assign push_ok_c = push && (!full || pop_ok_c);
    assign rd_data   = mem[rd_ptr];
    assign level     = count;

    // Storage is cleared on reset so the head reads 8'h00 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= PTR_W'(wr_ptr + 1'b1);
            end
            if (pop_ok_c) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            count <= LVL_W'(count + LVL_W'(push_ok_c) - LVL_W'(pop_ok_c));
        end
    end

endmodule

// File: rtl/nibble_bus_receiver.sv
// Pairs nibbles sampled from the shared tristate bus into bytes (low first), buffers them,
// and flags abandoned half-bytes (timeout) and dropped bytes (overflow).
module nibble_bus_receiver
    import nibble_bus_receiver_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NIBBLE_W-1:0]     bus_i,
    input  logic                    bus_oe,
    output logic [BYTE_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    frame_err,
    output logic                    overflow
);

    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [TMR_W-1:0]    timer_q;
    logic [TMR_W-1:0]    timer_d;
    logic [NIBBLE_W-1:0] low_q;
    logic [NIBBLE_W-1:0] low_d;
    logic                frame_err_d;
    logic                overflow_d;
    logic                push_c;
    logic [BYTE_W-1:0]   byte_c;
    logic                full;
    logic                empty;

    assign byte_c    = {bus_i, low_q};
    assign out_valid = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            low_q     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            low_q     <= low_d;
            frame_err <= frame_err_d;
            overflow  <= overflow_d;
        end
    end

    // A strobe in HALF always completes the byte, even on the cycle the timer would expire.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        low_d       = low_q;
        push_c      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_oe) begin
                    low_d   = bus_i;
                    timer_d = '0;
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (bus_oe) begin
                    push_c  = 1'b1;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = TMR_W'(timer_q + 1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign overflow_d = push_c && full && !(out_ready && out_valid);

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (byte_c),
        .pop       (out_ready),
        .rd_data   (out_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

endmodule
